// File: rtl/ram_input_loader.sv
// ---------------------------------------------------------------------------
// ram_input_loader
//
// Write-side initiator for the 1-bit x 2**ADDR_WIDTH input-image RAM. Takes
// the image as a byte stream over a valid/ready handshake. Each byte is
// unpacked LSB-first into BYTE_WIDTH consecutive 1-bit RAM writes. The
// address walks 0 .. 2**ADDR_WIDTH-1, and then done pulses for one cycle.
//
// Ports
//   clk       : system clock, rising edge
//   rst       : synchronous, active-high reset
//   start     : one-cycle load request, honoured only in IDLE
//   abort     : synchronous cancel, returns to IDLE without done
//   in_byte   : inbound image data
//   in_valid  : in_byte is valid
//   in_ready  : loader accepts in_byte this cycle
//   ram_we    : RAM write enable
//   ram_addr  : RAM write address
//   ram_data  : RAM write data
//   busy      : a load is in progress (any state other than IDLE)
//   done      : one-cycle pulse after the last RAM write
// ---------------------------------------------------------------------------
module ram_input_loader #(
   parameter int ADDR_WIDTH = 10,
   parameter int BYTE_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [BYTE_WIDTH-1:0] in_byte,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_data,
   output logic                  busy,
   output logic                  done
);

   localparam int               BIT_W    = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BYTE_WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_BYTE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t                r_state,   w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_addr,    w_addr_nxt;
   logic [BIT_W-1:0]      r_bit_cnt, w_bit_cnt_nxt;
   logic [BYTE_WIDTH-1:0] r_shift,   w_shift_nxt;
   logic                  w_handshake;

   // Every output is decoded from registered state. The one exception is
   // abort, which masks in_ready combinationally. Without that mask, a byte
   // offered in the abort cycle would be consumed and then dropped.
   assign in_ready    = (r_state == S_WAIT_BYTE) && !abort;
   assign w_handshake = in_ready && in_valid;
   assign ram_we      = (r_state == S_SHIFT);
   assign ram_addr    = r_addr;
   assign ram_data    = r_shift[0];
   assign busy        = (r_state != S_IDLE);
   assign done        = (r_state == S_DONE);

   // NOTE: each signal written here gets a default first. If any path
   // through the case statement left a signal unassigned, a latch would be
   // inferred.
   always_comb begin
      w_state_nxt   = r_state;
      w_addr_nxt    = r_addr;
      w_bit_cnt_nxt = r_bit_cnt;
      w_shift_nxt   = r_shift;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_WAIT_BYTE;
               w_addr_nxt  = '0;
            end
         end

         S_WAIT_BYTE: begin
            if (w_handshake) begin
               w_state_nxt   = S_SHIFT;
               w_shift_nxt   = in_byte;
               w_bit_cnt_nxt = '0;
            end
         end

         S_SHIFT: begin
            w_shift_nxt   = r_shift >> 1;
            w_addr_nxt    = r_addr + 1'b1;
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            // On the last bit of a byte, check whether this write hit the
            // top address. If so, the counter wraps to 0 and the load ends.
            if (r_bit_cnt == LAST_BIT) begin
               w_state_nxt = (r_addr == '1) ? S_DONE : S_WAIT_BYTE;
            end
         end

         S_DONE: begin
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Abort overrides every state transition above. A write already on
      // the RAM port in this cycle still lands, because ram_we is decoded
      // from the current state.
      if (abort && (r_state != S_IDLE)) begin
         w_state_nxt = S_IDLE;
         w_addr_nxt  = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only. Every
   // register updates from pre-edge values, so process order does not
   // matter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_addr    <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_addr    <= w_addr_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_shift   <= w_shift_nxt;
      end
   end

endmodule

// File: tb/tb_ram_input_loader.sv
// ---------------------------------------------------------------------------
// tb_ram_input_loader
//
// Directed bench for ram_input_loader at default parameters (1024 x 1 bit,
// 8-bit bytes). A negedge monitor captures every RAM write into a shadow
// array. It also checks that the address sequence is strictly 0,1,2,...
// within each load, and it counts in_ready and done cycles. The expected
// image, write counts and done timing are all computed here from the byte
// stream that the bench sends.
// ---------------------------------------------------------------------------
module tb_ram_input_loader;

   localparam int AW     = 10;
   localparam int BW     = 8;
   localparam int DEPTH  = 1 << AW;
   localparam int NBYTES = DEPTH / BW;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          abort;
   logic [BW-1:0] in_byte;
   logic          in_valid;
   logic          in_ready;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic          ram_data;
   logic          busy;
   logic          done;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ram_input_loader #(
      .ADDR_WIDTH (AW),
      .BYTE_WIDTH (BW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .in_byte  (in_byte),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_data (ram_data),
      .busy     (busy),
      .done     (done)
   );

   // ---------------- monitor ----------------
   int            cyc      = 0;
   int            load_id  = 0;
   int            mon_id   = 0;
   logic          mem [DEPTH];
   int            wr_cnt   = 0;
   int            rdy_cnt  = 0;
   int            done_cnt = 0;
   int            seq_err  = 0;
   int            last_addr = 0;
   logic [AW-1:0] exp_addr = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mon_id != load_id) begin
         mon_id    = load_id;
         wr_cnt    = 0;
         rdy_cnt   = 0;
         done_cnt  = 0;
         seq_err   = 0;
         last_addr = 0;
         exp_addr  = '0;
         for (int i = 0; i < DEPTH; i++) mem[i] = 1'b0;
      end
      if (ram_we) begin
         mem[ram_addr] = ram_data;
         if (ram_addr != exp_addr) seq_err++;
         exp_addr  = exp_addr + 1'b1;
         last_addr = int'(ram_addr);
         wr_cnt++;
      end
      if (in_ready) rdy_cnt++;
      if (done)     done_cnt++;
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   logic [BW-1:0] img [NBYTES];

   // Wait in WAIT_BYTE for `gap` idle cycles, then offer byte b. Returns at
   // the negedge just after the handshake edge.
   task automatic send_byte(input logic [BW-1:0] b, input int gap, input bit with_start);
      int t;
      in_valid = 1'b0;
      t = 0;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) check("ready_timeout", {31'd0, in_ready}, 1);
      repeat (gap) @(negedge clk);
      in_byte  = b;
      in_valid = 1'b1;
      if (with_start) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int dcyc);
      int t;
      t = 0;
      dcyc = -1;
      while (!done && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (done) dcyc = cyc;
      else check("done_timeout", {31'd0, done}, 1);
   endtask

   task automatic compare_image(input string tag);
      int mism;
      mism = 0;
      for (int a = 0; a < DEPTH; a++)
         if (mem[a] !== img[a / BW][a % BW]) mism++;
      check(tag, mism, 0);
   endtask

   // Full load of img[]. Random gaps of 0..max_gap cycles are inserted
   // before each byte. When pokes is set, start is pulsed around byte 10
   // and again in the DONE cycle.
   task automatic run_load(input string tag, input int max_gap, input bit pokes);
      int c, dcyc, g, gap_sum;
      load_id++;
      @(negedge clk);
      start = 1'b1;
      c     = cyc;
      @(negedge clk);
      start   = 1'b0;
      gap_sum = 0;
      for (int n = 0; n < NBYTES; n++) begin
         g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
         gap_sum += g;
         send_byte(img[n], g, pokes && (n == 10));
         if (pokes && n == 10) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      end
      wait_done(dcyc);
      if (pokes) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         #1;
         check({tag, "_busy_after_done_start"}, {31'd0, busy}, 0);
      end
      check({tag, "_done_cycle"}, dcyc, c + NBYTES * (BW + 1) + 1 + gap_sum);
      repeat (3) @(negedge clk);
      #1;
      check({tag, "_writes"},   wr_cnt,   DEPTH);
      check({tag, "_addr_seq"}, seq_err,  0);
      check({tag, "_done_cnt"}, done_cnt, 1);
      check({tag, "_rdy_cnt"},  rdy_cnt,  NBYTES + gap_sum);
      check({tag, "_busy_end"}, {31'd0, busy}, 0);
      compare_image({tag, "_image"});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t;
      logic [BW-1:0] first8;

      rst = 1'b1; start = 1'b1; abort = 1'b0; in_valid = 1'b1; in_byte = 8'hFF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 0);
      check("rst_ram_we",   {31'd0, ram_we},   0);
      check("rst_ram_addr", {22'd0, ram_addr}, 0);
      check("rst_ram_data", {31'd0, ram_data}, 0);
      check("rst_busy",     {31'd0, busy},     0);
      check("rst_done",     {31'd0, done},     0);
      rst = 1'b0; start = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      #1;
      check("idle_busy", {31'd0, busy}, 0);

      // Full load of 0xA5, in_valid effectively always high.
      for (int n = 0; n < NBYTES; n++) img[n] = 8'hA5;
      run_load("a5", 0, 1'b0);
      for (int k = 0; k < BW; k++) first8[k] = mem[k];
      check("a5_first_byte", {24'd0, first8}, 32'hA5);

      // Backpressure with 0..5 cycle gaps.
      for (int n = 0; n < NBYTES; n++) begin
         case (n % 4)
            0:       img[n] = 8'h01;
            1:       img[n] = 8'h80;
            2:       img[n] = 8'hFF;
            default: img[n] = 8'h00;
         endcase
      end
      run_load("gap", 5, 1'b0);

      // start pulses during the load and in the DONE cycle.
      for (int n = 0; n < NBYTES; n++) img[n] = BW'(n) ^ 8'h3C;
      run_load("poke", 0, 1'b1);

      // Abort on the 3rd write of byte 5 (addr 42).
      load_id++;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int n = 0; n < 6; n++) send_byte(8'hFF, 0, 1'b0);
      t = 0;
      while (!(ram_we && ram_addr == AW'(42)) && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("abort_addr", {22'd0, ram_addr}, 42);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      #1;
      check("abort_busy",  {31'd0, busy},   0);
      check("abort_we",    {31'd0, ram_we}, 0);
      repeat (4) @(negedge clk);
      #1;
      check("abort_writes",   wr_cnt,    43);
      check("abort_last",     last_addr, 42);
      check("abort_done",     done_cnt,  0);
      check("abort_mem42",    {31'd0, mem[42]}, 1);

      // Abort coinciding with an offered byte: abort wins.
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      in_byte = 8'hFF; in_valid = 1'b1; abort = 1'b1;
      #1;
      check("abort_hs_ready", {31'd0, in_ready}, 0);
      @(negedge clk);
      abort = 1'b0; in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("abort_hs_busy",   {31'd0, busy}, 0);
      check("abort_hs_writes", wr_cnt, 43);

      // Reload after the aborts starts from address 0.
      for (int n = 0; n < NBYTES; n++) img[n] = BW'(n * 7 + 3);
      run_load("reload", 0, 1'b0);

      // rst in WAIT_BYTE with in_valid high at byte 64.
      load_id++;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int n = 0; n < 64; n++) send_byte(8'h96, 0, 1'b0);
      in_valid = 1'b0;
      t = 0;
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      in_byte = 8'h5A; in_valid = 1'b1; rst = 1'b1;
      @(negedge clk);
      #1;
      check("mrst_in_ready", {31'd0, in_ready}, 0);
      check("mrst_busy",     {31'd0, busy},     0);
      check("mrst_ram_we",   {31'd0, ram_we},   0);
      check("mrst_ram_addr", {22'd0, ram_addr}, 0);
      check("mrst_ram_data", {31'd0, ram_data}, 0);
      rst = 1'b0; in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("mrst_writes", wr_cnt,   512);
      check("mrst_done",   done_cnt, 0);

      for (int n = 0; n < NBYTES; n++) img[n] = ~BW'(n);
      run_load("post_rst", 2, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ram_input_loader.md
Name: ram_input_loader

Overview:
- Write-side initiator for the 1-bit x 1024-entry input-image RAM.
- Accepts an image as a byte stream over a valid/ready handshake and unpacks each byte LSB-first into 8 consecutive 1-bit RAM writes.
- Walks the address from 0 to 2**ADDR_WIDTH-1, then pulses done.
- Sits between the host byte source (UART/bus) and the RAM write port. Read-side consumers use the RAM only after done.

Parameters:
- ADDR_WIDTH, 10: RAM address width; image size = 2**ADDR_WIDTH bits = 2**ADDR_WIDTH/8 bytes (128 at default).
- BYTE_WIDTH, 8: width of the inbound stream word; bits are written LSB-first; 2**ADDR_WIDTH must be a multiple of BYTE_WIDTH.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to begin a load; honoured only in IDLE
- abort  input  1  synchronous cancel; returns to IDLE without done
- in_byte  input  BYTE_WIDTH  inbound image data
- in_valid  input  1  in_byte valid
- in_ready  output  1  loader can accept in_byte this cycle
- ram_we  output  1  RAM write enable
- ram_addr  output  ADDR_WIDTH  RAM write address
- ram_data  output  1  RAM write data
- busy  output  1  load in progress (any state other than IDLE)
- done  output  1  one-cycle pulse after the last RAM write

Behaviour:
- States: IDLE, WAIT_BYTE, SHIFT, DONE.
- All outputs are decoded from registered state, the address counter, the bit counter and the shift register. No combinational path exists from in_valid to in_ready.
- Reset (rst=1 at an edge):
  - state=IDLE; addr counter=0; bit counter=0; shift reg=0.
  - Outputs: in_ready=0, ram_we=0, ram_addr=0, ram_data=0, busy=0, done=0.
  - rst has priority over abort and start.
- IDLE:
  - in_ready=0, ram_we=0, busy=0.
  - start=1 -> WAIT_BYTE; addr counter cleared to 0.
- WAIT_BYTE:
  - in_ready=1, ram_we=0.
  - Handshake occurs at an edge with in_valid=1 and in_ready=1. That edge loads in_byte into the shift reg, clears the bit counter and moves to SHIFT.
  - in_valid=0 holds in WAIT_BYTE indefinitely.
- SHIFT:
  - Lasts exactly BYTE_WIDTH cycles. in_ready=0, ram_we=1, ram_addr=addr counter, ram_data=shift_reg[0].
  - Each edge: shift reg shifts right by 1, addr counter +1, bit counter +1.
  - After the BYTE_WIDTH-th write: if the write just performed was to address 2**ADDR_WIDTH-1, go to DONE (addr counter wraps to 0). Otherwise go to WAIT_BYTE.
- DONE:
  - Lasts one cycle. done=1, busy=1, ram_we=0, in_ready=0.
  - Next edge -> IDLE.
- Latency: for a handshake at edge E0, bit k of the byte is written at edge E(k+1), for k=0..7. in_ready is high again in the cycle after E8. Peak throughput is one byte per BYTE_WIDTH+1 cycles.
- Full image at default parameters: 128 byte handshakes, 1024 writes, a single done pulse.
- Address wrap: the counter is ADDR_WIDTH bits. Wrap to 0 happens only on the final write. No write ever targets an address twice in one load.
- start while busy: ignored with no effect, including during DONE.
- abort=1 at an edge in any non-IDLE state:
  - Next state is IDLE and the addr counter is cleared.
  - In that cycle the loader issues no handshake and asserts no done.
  - A write already presented (ram_we=1) in the abort cycle still completes. No further writes follow.
  - Previously written RAM contents are left as-is.
- Simultaneous abort and handshake: abort wins. The byte is not consumed because in_ready is forced to 0 combinationally from abort.
- rst mid-load: same as abort, plus all registers return to reset values. A later start begins at address 0.
- in_byte/in_valid are don't-care outside WAIT_BYTE.

Test Plan:
- Reset values: hold rst 2 cycles with in_valid=1 and start=1 -> all outputs 0, state IDLE, no ram_we.
- Full load: start, then stream 128 bytes of 0xA5 with in_valid always high -> writes 1,0,1,0,0,1,0,1 at addr 0..7, the same pattern repeated through addr 1023. Exactly 1024 ram_we cycles, in_ready every 9th cycle, done high for exactly 1 cycle at 128*9+1 cycles after start, then busy=0.
- Backpressure: insert random 0-5 cycle in_valid gaps; bytes 0x01, 0x80, 0xFF, 0x00 repeated -> RAM contents match the model bit-for-bit, no writes during gaps, done timing shifts by exactly the total gap cycles.
- start during load: pulse start at byte 10 and in the DONE cycle -> no effect on the address sequence, only one done pulse.
- Abort mid-SHIFT: abort on the 3rd write of byte 5 (addr 42) -> addr 42 written, no write to addr 43, busy=0 next cycle, no done. A new start reloads from addr 0.
- rst mid-WAIT_BYTE with in_valid=1 at byte 64 -> byte not consumed, outputs at reset values, subsequent full load completes correctly with done once.
